div_issue: RTL and testbench
============================

Name: div_issue

Overview:
- Requester-side controller for the iterative divider. Sits in the EX stage between the decoded DIV/DIVU instruction and the divider's start/cancel/done handshake.
- Launches a division and holds the pipeline stalled until the result returns. Delivers the remainder to HI and the quotient to LO.
- Aborts the division cleanly when the pipeline flushes, and enforces the divider's return-to-idle rules so that back-to-back divisions are safe.

Parameters:
DRAIN_CYCLES, 2, cycles start is held low after completion/cancel before a new issue (divider return-to-idle time)

Ports:
clk  input  1  core clock
rst  input  1  reset, asynchronous, active-high
ex_div_req  input  1  EX stage holds a DIV/DIVU instruction
ex_div_signed  input  1  1 = DIV (signed), 0 = DIVU
ex_opdata1  input  `RegWidth  dividend (rs)
ex_opdata2  input  `RegWidth  divisor (rt)
flush  input  1  pipeline flush (exception/eret)
div_res  input  `DoubleRegWidth  divider result {remainder, quotient}
div_done  input  1  divider result valid
signed_div  output  1  to divider
div_opdata1  output  `RegWidth  to divider, dividend
div_opdata2  output  `RegWidth  to divider, divisor
div_start  output  1  to divider, start level
div_cancel  output  1  to divider, abort
stall_req  output  1  request EX (and earlier) stall
hilo_we  output  1  write HI/LO this cycle
hi_o  output  `RegWidth  remainder
lo_o  output  `RegWidth  quotient

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; drain counter=0.
  - signed_div, div_opdata1/2, div_start all 0; div_cancel=0.
  - stall_req=0, hilo_we=0, hi_o=lo_o=0.
- Divider contract (fixed):
  - The divider samples start only when idle, and ignores start while cancel=1.
  - Operands and signed_div must stay stable while start=1.
  - div_done and div_res are held while start stays 1. The divider returns to idle one cycle after it sees start=0.
  - A divisor of 0 gives done with a result of 0.
  - cancel is honoured only during iteration.
- States: IDLE, BUSY, DRAIN.
- IDLE:
  - If ex_div_req=1 and flush=0: register the operands and signed_div, set div_start<=1, go to BUSY.
  - stall_req=ex_div_req (combinational) in IDLE.
- BUSY, stall_req=1 except on the done cycle:
  - div_done=1 and flush=0: combinationally drive hilo_we=1, hi_o=div_res[63:32], lo_o=div_res[31:0], stall_req=0. Then div_start<=0, counter<=DRAIN_CYCLES, go to DRAIN. The instruction advances on this same cycle.
  - flush=1 (takes priority over done): div_cancel=1 combinationally, hilo_we=0, stall_req=0. Then div_start<=0 and go to DRAIN.
- DRAIN:
  - div_start=0; count down to 0, then go to IDLE.
  - stall_req=ex_div_req, so a following DIV waits.
  - flush is ignored; nothing is pending.
- Output rules:
  - hilo_we is a single-cycle pulse per completed division; it is never asserted after a cancel.
  - hi_o and lo_o are 0 whenever hilo_we=0.
  - div_cancel is 0 outside BUSY.
- Simultaneous and repeat events:
  - flush together with ex_div_req in IDLE: no issue.
  - Operands changing at the input while in BUSY are ignored; the registered copies drive the divider.
  - The same instruction is never re-issued, because DRAIN separates completion from the next IDLE sample.
- Latency: issue-to-hilo_we = divider latency + 1 registered start cycle. Back-to-back division spacing ≥ DRAIN_CYCLES+1 extra cycles.

Decomposition:
- The shared defines file gains:
  - `DivIssueIdle, `DivIssueBusy, `DivIssueDrain (2-bit state codes);
  - `DivDrainCycles.
- `RegWidth, `DoubleRegWidth and `RstEnable are reused from the existing defines.
- No sub-module; the testbench instantiates div_issue with the existing divider.

Test Plan:
- Signed 100 / 7 (DIV): hilo_we pulses once, hi_o=0x00000002, lo_o=0x0000000E. stall_req=1 from issue until the done cycle.
- Signed 0xFFFFFFF9 / 2 (−7/2): lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF.
- Unsigned 0xFFFFFFFF / 0x10 (DIVU): lo_o=0x0FFFFFFF, hi_o=0x0000000F.
- Divide by zero (5 / 0): hilo_we pulses with hi_o=lo_o=0, a few cycles after issue. Then DRAIN, then IDLE.
- Flush on the 10th BUSY cycle:
  - div_cancel=1 for exactly one cycle; no hilo_we; div_start drops.
  - A next DIV of 9/3 issued right after yields lo_o=3, hi_o=0.
- Back-to-back DIVs (20/6 then 21/4):
  - Two hilo_we pulses: (hi=2, lo=3), then (hi=1, lo=5).
  - div_start is low for ≥DRAIN_CYCLES cycles between them.
  - Assert reset mid-BUSY: all outputs are 0 on the next sample.

Source files
------------

// File: rtl/div_issue_pkg.sv
// Shared widths, drain time and state codes for the divider issue controller.
package div_issue_pkg;

  localparam int unsigned REG_WIDTH        = 32;
  localparam int unsigned DOUBLE_REG_WIDTH = 64;
  localparam int unsigned DIV_DRAIN_CYCLES = 2;

  typedef enum logic [1:0] {
    DIV_ISSUE_IDLE  = 2'b00,
    DIV_ISSUE_BUSY  = 2'b01,
    DIV_ISSUE_DRAIN = 2'b10
  } div_issue_state_e;

  // Drain counter width; at least one bit so a zero drain time still builds.
  function automatic int unsigned drain_cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/div_issue.sv
// EX-stage requester for the iterative divider: issues DIV/DIVU, stalls until the
// result returns, writes HI/LO, and cancels cleanly on a pipeline flush.
//
// state | meaning
// IDLE  | no division outstanding; a DIV in EX is issued unless flushed
// BUSY  | start held high; waiting for done, or cancelling on flush
// DRAIN | start held low so the divider is back in idle before the next issue
module div_issue
  import div_issue_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = DIV_DRAIN_CYCLES
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ex_div_req,
  input  logic                        ex_div_signed,
  input  logic [REG_WIDTH-1:0]        ex_opdata1,
  input  logic [REG_WIDTH-1:0]        ex_opdata2,
  input  logic                        flush,
  input  logic [DOUBLE_REG_WIDTH-1:0] div_res,
  input  logic                        div_done,
  output logic                        signed_div,
  output logic [REG_WIDTH-1:0]        div_opdata1,
  output logic [REG_WIDTH-1:0]        div_opdata2,
  output logic                        div_start,
  output logic                        div_cancel,
  output logic                        stall_req,
  output logic                        hilo_we,
  output logic [REG_WIDTH-1:0]        hi_o,
  output logic [REG_WIDTH-1:0]        lo_o
);

  localparam int unsigned CNT_W = drain_cnt_width(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);

  div_issue_state_e     state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 start_q, start_d;
  logic                 sgn_q, sgn_d;
  logic [REG_WIDTH-1:0] op1_q, op1_d;
  logic [REG_WIDTH-1:0] op2_q, op2_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DIV_ISSUE_IDLE;
      cnt_q   <= '0;
      start_q <= 1'b0;
      sgn_q   <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      sgn_q   <= sgn_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    start_d    = start_q;
    sgn_d      = sgn_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    div_cancel = 1'b0;
    stall_req  = 1'b0;
    hilo_we    = 1'b0;
    hi_o       = '0;
    lo_o       = '0;

    case (state_q)
      DIV_ISSUE_IDLE: begin
        stall_req = ex_div_req;
        if (ex_div_req && !flush) begin
          sgn_d   = ex_div_signed;
          op1_d   = ex_opdata1;
          op2_d   = ex_opdata2;
          start_d = 1'b1;
          state_d = DIV_ISSUE_BUSY;
        end
      end

      DIV_ISSUE_BUSY: begin
        stall_req = 1'b1;
        // Flush wins over a coincident done: the instruction is being killed.
        if (flush) begin
          div_cancel = 1'b1;
          stall_req  = 1'b0;
          start_d    = 1'b0;
          cnt_d      = DRAIN_LOAD;
          state_d    = DIV_ISSUE_DRAIN;
        end else if (div_done) begin
          hilo_we   = 1'b1;
          hi_o      = div_res[DOUBLE_REG_WIDTH-1:REG_WIDTH];
          lo_o      = div_res[REG_WIDTH-1:0];
          stall_req = 1'b0;
          start_d   = 1'b0;
          cnt_d     = DRAIN_LOAD;
          state_d   = DIV_ISSUE_DRAIN;
        end
      end

      DIV_ISSUE_DRAIN: begin
        stall_req = ex_div_req;
        start_d   = 1'b0;
        if (cnt_q == '0) begin
          state_d = DIV_ISSUE_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        start_d = 1'b0;
        state_d = DIV_ISSUE_IDLE;
      end
    endcase
  end

  assign signed_div  = sgn_q;
  assign div_opdata1 = op1_q;
  assign div_opdata2 = op2_q;
  assign div_start   = start_q;

endmodule

// File: tb/tb_div_issue.sv
// Self-checking bench for div_issue with a behavioural divider and a result reference.
module tb_div_issue;
  import div_issue_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_div_req, ex_div_signed, flush;
  logic [31:0] ex_opdata1, ex_opdata2;
  logic [63:0] div_res;
  logic        div_done;
  logic        signed_div, div_start, div_cancel, stall_req, hilo_we;
  logic [31:0] div_opdata1, div_opdata2, hi_o, lo_o;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  int exp_pulses = 0;
  int low_run = 0;
  int dv_lat = 1;

  always #5 clk = ~clk;

  div_issue dut (
    .clk(clk), .rst(rst), .ex_div_req(ex_div_req), .ex_div_signed(ex_div_signed),
    .ex_opdata1(ex_opdata1), .ex_opdata2(ex_opdata2), .flush(flush),
    .div_res(div_res), .div_done(div_done), .signed_div(signed_div),
    .div_opdata1(div_opdata1), .div_opdata2(div_opdata2), .div_start(div_start),
    .div_cancel(div_cancel), .stall_req(stall_req), .hilo_we(hilo_we),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // MIPS-style division: quotient truncates toward zero, remainder takes the dividend's sign.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    logic [31:0] q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = a;
        r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Divider stand-in: samples start when idle and not cancelled, done after dv_lat cycles.
  int          dv_st;
  int          dv_cnt;
  logic [63:0] dv_hold;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dv_st    <= 0;
      dv_cnt   <= 0;
      dv_hold  <= '0;
      div_done <= 1'b0;
      div_res  <= '0;
    end else begin
      case (dv_st)
        0: if (div_start && !div_cancel) begin
             dv_cnt  <= dv_lat - 1;
             dv_hold <= ref_div(div_opdata1, div_opdata2, signed_div);
             dv_st   <= 1;
           end
        1: if (div_cancel || !div_start) dv_st <= 0;
           else if (dv_cnt == 0) begin
             dv_st    <= 2;
             div_done <= 1'b1;
             div_res  <= dv_hold;
           end else dv_cnt <= dv_cnt - 1;
        default: if (!div_start) begin
             dv_st    <= 0;
             div_done <= 1'b0;
             div_res  <= '0;
           end
      endcase
    end
  end

  always @(negedge clk) low_run <= div_start ? 0 : low_run + 1;

  always @(negedge clk) begin
    #1;
    if (hilo_we) pulses++;
    else check_eq("hilo_idle_zero", {hi_o, lo_o}, 64'd0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input logic [31:0] ehi, input logic [31:0] elo,
                         input int flush_k, input bit b2b, input bit keep);
    int lat, gap, n;
    lat = (b == 32'd0) ? 1 : int'($urandom_range(12, 40));
    dv_lat = lat;
    @(negedge clk);
    ex_div_req = 1'b1; ex_div_signed = sgn; ex_opdata1 = a; ex_opdata2 = b; flush = 1'b0;
    #1;
    n = 0; gap = 0;
    while (!div_start && n < 20) begin
      check_eq("stall_wait", stall_req, 1);
      gap = low_run;
      @(negedge clk); #1;
      n++;
    end
    if (!div_start) begin
      check_eq("issue_timeout", 0, 1);
      ex_div_req = 1'b0;
      return;
    end
    if (b2b) check_eq("drain_gap", gap, DIV_DRAIN_CYCLES + 2);
    for (int k = 1; k <= lat + 2; k++) begin
      if (k > 1) @(negedge clk);
      ex_opdata1 = $urandom; ex_opdata2 = $urandom; ex_div_signed = 1'($urandom);
      if (k == flush_k) flush = 1'b1;
      #1;
      check_eq("op_hold", {div_opdata1, div_opdata2}, {a, b});
      check_eq("sgn_hold", signed_div, sgn);
      if (k == flush_k) begin
        check_eq("cancel", {div_cancel, hilo_we, stall_req, div_start}, 4'b1001);
        @(negedge clk);
        flush = 1'b0; ex_div_req = 1'b0;
        #1;
        check_eq("after_cancel", {div_cancel, div_start, hilo_we, stall_req}, 4'b0000);
        return;
      end
      if (k == lat + 2) begin
        check_eq("done_ctl", {hilo_we, stall_req, div_cancel}, 3'b100);
        check_eq("result", {hi_o, lo_o}, {ehi, elo});
        exp_pulses++;
      end else begin
        check_eq("busy_ctl", {hilo_we, stall_req, div_cancel, div_start}, 4'b0101);
      end
    end
    if (!keep) begin
      @(negedge clk);
      ex_div_req = 1'b0;
      #1;
      check_eq("post_done", {hilo_we, div_start, stall_req, div_cancel}, 4'b0000);
    end
  endtask

  task automatic reset_mid_busy();
    int n;
    dv_lat = 30;
    @(negedge clk);
    ex_div_req = 1'b1; ex_div_signed = 1'b1; ex_opdata1 = 32'd77; ex_opdata2 = 32'd5;
    n = 0;
    while (!div_start && n < 20) begin @(negedge clk); n++; end
    check_eq("rst_issue", div_start, 1);
    repeat (4) @(negedge clk);
    rst = 1'b1; ex_div_req = 1'b0;
    #1;
    check_eq("rst_ops", {signed_div, div_opdata1, div_opdata2}, 65'd0);
    check_eq("rst_ctl", {div_start, div_cancel, stall_req, hilo_we, hi_o, lo_o}, 68'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] a, b;
    logic        sgn;
    logic [63:0] e;
    int          fk;

    rst = 1'b1; ex_div_req = 1'b0; ex_div_signed = 1'b0; flush = 1'b0;
    ex_opdata1 = '0; ex_opdata2 = '0;
    #1;
    check_eq("reset_ops", {signed_div, div_opdata1, div_opdata2}, 65'd0);
    check_eq("reset_ctl", {div_start, div_cancel, stall_req, hilo_we, hi_o, lo_o}, 68'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_div(32'd100, 32'd7, 1'b1, 32'h2, 32'hE, 0, 1'b0, 1'b0);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 1'b1, 1'b0);
    run_div(32'hFFFF_FFFF, 32'h10, 1'b0, 32'hF, 32'h0FFF_FFFF, 0, 1'b1, 1'b0);
    run_div(32'd5, 32'd0, 1'b0, 32'h0, 32'h0, 0, 1'b1, 1'b0);
    run_div(32'd1000, 32'd3, 1'b1, 32'h0, 32'h0, 10, 1'b1, 1'b0);
    run_div(32'd9, 32'd3, 1'b1, 32'h0, 32'h3, 0, 1'b1, 1'b0);
    run_div(32'd20, 32'd6, 1'b1, 32'h2, 32'h3, 0, 1'b1, 1'b1);
    run_div(32'd21, 32'd4, 1'b1, 32'h1, 32'h5, 0, 1'b1, 1'b0);

    // Flush coinciding with a DIV in IDLE must not issue it.
    repeat (6) @(negedge clk);
    ex_div_req = 1'b1; ex_opdata1 = 32'd8; ex_opdata2 = 32'd2; flush = 1'b1;
    #1;
    check_eq("idle_flush_stall", stall_req, 1);
    @(negedge clk); #1;
    check_eq("idle_flush_noissue", {div_start, div_cancel}, 2'b00);
    ex_div_req = 1'b0; flush = 1'b0;

    reset_mid_busy();
    repeat (4) @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      a   = $urandom;
      sgn = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 255);
        2:       b = -$urandom_range(1, 255);
        default: b = $urandom;
      endcase
      e  = ref_div(a, b, sgn);
      fk = ($urandom_range(0, 3) == 0 && b != 32'd0) ? int'($urandom_range(1, 12)) : 0;
      run_div(a, b, sgn, e[63:32], e[31:0], fk, i > 0, 1'($urandom));
    end
    @(negedge clk);
    ex_div_req = 1'b0;
    repeat (6) @(negedge clk);
    #2;
    check_eq("pulse_count", pulses, exp_pulses);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
